// File: rtl/sync_fifo_flags.sv
// Synchronous single-clock FIFO with arbitrary depth, occupancy count, programmable
// almost-full/almost-empty thresholds, optional FWFT read, flush and sticky error flags.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 7,
    parameter int FWFT       = 0,
    parameter int AFULL_TH   = DEPTH - 1,
    parameter int AEMPTY_TH  = 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AFULL_TH);
    localparam logic [CW-1:0] AE_C     = CW'(AEMPTY_TH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         w_ptr;
    logic [PW-1:0]         r_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // Full/empty gating alone resolves simultaneous access at the boundaries.
    assign wr_acc = w_en && !full && !flush;
    assign rd_acc = r_en && !empty && !flush;

    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[w_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            w_ptr <= '0;
            r_ptr <= '0;
            count <= '0;
        end else begin
            if (wr_acc) begin
                w_ptr <= (w_ptr == LAST_PTR) ? '0 : w_ptr + PW'(1);
            end
            if (rd_acc) begin
                r_ptr <= (r_ptr == LAST_PTR) ? '0 : r_ptr + PW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && full && !flush) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (r_en && empty && !flush) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem[r_ptr];
                end
            end
            assign data_out = dout_q;
        end else begin : g_fwft
            assign data_out = empty ? '0 : mem[r_ptr];
        end
    endgenerate

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised synchronous single-clock FIFO. It is the next-generation replacement for the team's basic FIFO. Arbitrary (non-power-of-two) depth, a full-width occupancy count, programmable almost-full/almost-empty thresholds, selectable standard or first-word-fall-through (FWFT) read mode, synchronous flush, and sticky overflow/underflow error flags. Used as the generic buffering element between streaming datapath stages.

## Interface
- DATA_WIDTH, 8, width of data words
- DEPTH, 7, number of storage entries; any value >= 2
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AFULL_TH, DEPTH-1, almost_full asserted when count >= AFULL_TH
- AEMPTY_TH, 1, almost_empty asserted when count <= AEMPTY_TH
- CW (local), $clog2(DEPTH+1), count width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of contents
- w_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- r_en  in  1  read request
- data_out  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_TH
- almost_empty  out  1  count <= AEMPTY_TH
- count  out  CW  current occupancy, 0..DEPTH
- clr_err  in  1  clears sticky error flags
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Accepted write: w_en && !full && !flush. Accepted read: r_en && !empty && !flush.
- Accepted write stores data_in at w_ptr. Accepted read advances r_ptr.
- Pointers are 0..DEPTH-1 and wrap from DEPTH-1 to 0 explicitly, with no reliance on power-of-two rollover.
- count update: +1 on write only, -1 on read only, unchanged on both or neither. It never leaves 0..DEPTH.
- Full with w_en and r_en in the same cycle: the read is accepted, the write is dropped, overflow is set, and count becomes DEPTH-1.
- Empty with w_en and r_en in the same cycle: the write is accepted, the read is rejected, underflow is set, and count becomes 1.
- FWFT=0: data_out is registered. It is loaded with mem[r_ptr] on an accepted read and holds its value otherwise.
- FWFT=1: data_out = mem[r_ptr] combinationally while !empty, and 0 while empty. An accepted read pops the displayed word.
- Flags full, empty, almost_full and almost_empty are combinational decodes of the registered count.
- overflow is set by w_en && full && !flush. underflow is set by r_en && empty && !flush.
  - Both stay set until clr_err or reset.
  - If clr_err and a new error event occur in the same cycle, the flag is set (set wins).
- flush: w_ptr, r_ptr and count go to 0 on that edge.
  - w_en and r_en in the flush cycle are ignored and raise no error.
  - data_out (FWFT=0) and the error flags are unaffected.
- rst_n low, including mid-operation:
  - w_ptr = r_ptr = count = 0.
  - data_out = 0, overflow = underflow = 0.
  - Therefore empty = 1, full = 0, almost_empty = 1 (AEMPTY_TH >= 0), and almost_full = (AFULL_TH == 0).
- Memory contents are not reset.

## Timing
- Write-to-read visibility: a word written at edge N is readable from cycle N+1.
  - FWFT=1: data_out is valid at N+1.
  - FWFT=0: data_out is valid after the read-accept edge at N+1 or later.
- FWFT=0 read latency is 1 cycle from the accepting edge to data_out.
- FWFT=1 read latency is 0: data is presented before the read.
- count and all status flags reflect the edge that updated count. No extra pipeline stage.
- Throughput: one write and one read per cycle, sustained, when neither full nor empty.
- Error flags assert on the edge following the offending request.

## Test plan
- **Fill and drain.** DEPTH=7, FWFT=0: write 0x01..0x07 on 7 consecutive cycles, then read 7 times.
  - full=1 and count=7 after the 7th write.
  - data_out = 0x01..0x07 in order, each 1 cycle after its read.
  - empty=1 at the end.
- **Wrap-around.** DEPTH=5, 13 interleaved write/read cycles with occupancy held at 2–3.
  - Pointers pass 4->0 at least twice.
  - Data order is preserved and count is never >5.
- **Simultaneous access at the boundaries.**
  - Full with w_en=r_en=1: count -> 6, overflow=1, the dropped word never appears.
  - Empty with w_en=r_en=1: count -> 1, underflow=1.
  - clr_err then clears both.
- **FWFT and thresholds.** FWFT=1, AFULL_TH=5, AEMPTY_TH=1: write 0xA5.
  - data_out = 0xA5 in the next cycle without r_en, and almost_empty=1.
  - After 5 words: almost_full=1. After a read: almost_full=0.
- **Flush and reset mid-operation.** Load 4 words.
  - Assert flush with w_en=r_en=1: count=0, empty=1, no error flag raised.
  - Refill 3 words and pulse rst_n=0: all outputs at their reset values next cycle.
- **Error precedence.** Assert clr_err together with w_en while full: overflow remains 1.
